// File: rtl/stack_access_sequencer.sv
// stack_access_sequencer
//   Bus-side partner of the stack pointer register. Runs 1..3 byte push or
//   pull sequences against page-one stack memory.
//     push byte: write at SP, then pulse sp_decrement
//     pull byte: pulse sp_increment, then read at SP
//
// Ports
//   fclk, reset        clock (rising edge), async active-high reset
//   start, pull        begin a sequence (sampled in IDLE only); 0=push 1=pull
//   byte_count         bytes to move, 1..3 (0 ignores start)
//   push_data          push order [23:16], [15:8], [7:0]
//   sp_in              current stack pointer
//   ready              bus cycle completes on an edge with ready=1
//   db_in              read data, sampled on the completing read edge
//   address_out        {STACK_PAGE, sp_in} while bus_valid, else 0
//   db_out, rw         write data (0 when not writing); 1=read / idle
//   bus_valid          stack bus cycle in progress
//   sp_increment/dec   one-cycle pulses to the SP register
//   pull_data          1st pulled byte in [7:0], 2nd [15:8], 3rd [23:16]
//   busy, done         busy in every non-IDLE state; done pulses at the end
//   stack_error        sticky SP wrap flag
//
// Optional build macro STACK_SEQ_WRAP_DETECT_EN enables wrap detection;
// without it stack_error is tied low.

module stack_access_sequencer #(
    parameter logic [7:0] STACK_PAGE = 8'h01
) (
    input  logic        fclk,
    input  logic        reset,
    input  logic        start,
    input  logic        pull,
    input  logic [1:0]  byte_count,
    input  logic [23:0] push_data,
    input  logic [7:0]  sp_in,
    input  logic        ready,
    input  logic [7:0]  db_in,
    output logic [15:0] address_out,
    output logic [7:0]  db_out,
    output logic        rw,
    output logic        bus_valid,
    output logic        sp_increment,
    output logic        sp_decrement,
    output logic [23:0] pull_data,
    output logic        busy,
    output logic        done,
    output logic        stack_error
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH_WR,
        PUSH_DEC,
        PULL_INC,
        PULL_RD,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  rem_q, rem_d;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] push_sh_q, push_sh_d;
    logic [23:0] pull_data_q, pull_data_d;
    logic        bus_valid_q, bus_valid_d;
    logic        rw_q, rw_d;
    logic [7:0]  db_out_q, db_out_d;
    logic        sp_inc_q, sp_inc_d;
    logic        sp_dec_q, sp_dec_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        idx_d       = idx_q;
        push_sh_d   = push_sh_q;
        pull_data_d = pull_data_q;

        case (state_q)
            IDLE: begin
                if (start && (byte_count != 2'd0)) begin
                    rem_d     = byte_count;
                    idx_d     = 2'd0;
                    push_sh_d = push_data;
                    if (pull) begin
                        pull_data_d = '0;
                        state_d     = PULL_INC;
                    end else begin
                        state_d = PUSH_WR;
                    end
                end
            end
            PUSH_WR: begin
                if (ready) state_d = PUSH_DEC;
            end
            PUSH_DEC: begin
                // Next push byte is always at the top of the shift register
                rem_d     = rem_q - 2'd1;
                push_sh_d = {push_sh_q[15:0], 8'h00};
                state_d   = (rem_q == 2'd1) ? DONE : PUSH_WR;
            end
            PULL_INC: begin
                state_d = PULL_RD;
            end
            PULL_RD: begin
                if (ready) begin
                    case (idx_q)
                        2'd0:    pull_data_d[7:0]   = db_in;
                        2'd1:    pull_data_d[15:8]  = db_in;
                        default: pull_data_d[23:16] = db_in;
                    endcase
                    idx_d   = idx_q + 2'd1;
                    rem_d   = rem_q - 2'd1;
                    state_d = (rem_q == 2'd1) ? DONE : PULL_INC;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are registered
        // yet line up with the state they describe.
        bus_valid_d = (state_d == PUSH_WR) || (state_d == PULL_RD);
        rw_d        = (state_d != PUSH_WR);
        db_out_d    = (state_d == PUSH_WR) ? push_sh_d[23:16] : 8'h00;
        sp_inc_d    = (state_d == PULL_INC);
        sp_dec_d    = (state_d == PUSH_DEC);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge fclk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            idx_q       <= '0;
            push_sh_q   <= '0;
            pull_data_q <= '0;
            bus_valid_q <= 1'b0;
            rw_q        <= 1'b1;
            db_out_q    <= '0;
            sp_inc_q    <= 1'b0;
            sp_dec_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            idx_q       <= idx_d;
            push_sh_q   <= push_sh_d;
            pull_data_q <= pull_data_d;
            bus_valid_q <= bus_valid_d;
            rw_q        <= rw_d;
            db_out_q    <= db_out_d;
            sp_inc_q    <= sp_inc_d;
            sp_dec_q    <= sp_dec_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef STACK_SEQ_WRAP_DETECT_EN
    logic stack_error_q, stack_error_d;

    // sp_in still holds the pre-update value during the pulse state
    always_comb begin
        stack_error_d = stack_error_q
                      | ((state_q == PUSH_DEC) && (sp_in == 8'h00))
                      | ((state_q == PULL_INC) && (sp_in == 8'hFF));
    end

    always_ff @(posedge fclk or posedge reset) begin
        if (reset) stack_error_q <= 1'b0;
        else       stack_error_q <= stack_error_d;
    end

    assign stack_error = stack_error_q;
`else
    assign stack_error = 1'b0;
`endif

    assign address_out  = bus_valid_q ? {STACK_PAGE, sp_in} : 16'h0000;
    assign db_out       = db_out_q;
    assign rw           = rw_q;
    assign bus_valid    = bus_valid_q;
    assign sp_increment = sp_inc_q;
    assign sp_decrement = sp_dec_q;
    assign pull_data    = pull_data_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_stack_access_sequencer.sv
// Testbench for stack_access_sequencer: SP register and page-one memory
// environment, per-cycle expected-output trace built from the sequence rules.

module tb_stack_access_sequencer;

`ifdef STACK_SEQ_WRAP_DETECT_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        fclk = 1'b0;
    logic        reset;
    logic        start;
    logic        pull;
    logic [1:0]  byte_count;
    logic [23:0] push_data;
    logic [7:0]  sp_in;
    logic        ready;
    logic [7:0]  db_in;
    logic [15:0] address_out;
    logic [7:0]  db_out;
    logic        rw;
    logic        bus_valid;
    logic        sp_increment;
    logic        sp_decrement;
    logic [23:0] pull_data;
    logic        busy;
    logic        done;
    logic        stack_error;

    always #5 fclk = ~fclk;

    stack_access_sequencer #(.STACK_PAGE(8'h01)) dut (
        .fclk(fclk), .reset(reset), .start(start), .pull(pull),
        .byte_count(byte_count), .push_data(push_data), .sp_in(sp_in),
        .ready(ready), .db_in(db_in), .address_out(address_out),
        .db_out(db_out), .rw(rw), .bus_valid(bus_valid),
        .sp_increment(sp_increment), .sp_decrement(sp_decrement),
        .pull_data(pull_data), .busy(busy), .done(done),
        .stack_error(stack_error)
    );

    // Environment: SP register and stack memory driven by DUT activity
    logic [7:0] sp_reg;
    logic [7:0] mem [256];
    logic       sp_ld;
    logic [7:0] sp_ld_val;
    logic       mem_copy;

    // Model state
    logic [7:0]  m_sp;
    logic [7:0]  m_mem [256];
    logic [23:0] m_pd;
    logic        m_err;

    assign sp_in = sp_reg;
    assign db_in = mem[sp_reg];

    always @(posedge fclk) begin
        if (mem_copy) begin
            for (int i = 0; i < 256; i++) mem[i] <= m_mem[i];
        end else if (bus_valid && !rw && ready) begin
            mem[sp_reg] <= db_out;
        end
        if (sp_ld)             sp_reg <= sp_ld_val;
        else if (sp_increment) sp_reg <= sp_reg + 8'd1;
        else if (sp_decrement) sp_reg <= sp_reg - 8'd1;
    end

    typedef struct packed {
        logic        bv, rw, inc, dec, busy, done, err;
        logic [15:0] addr;
        logic [7:0]  db;
        logic [23:0] pd;
    } exp_t;

    exp_t tr  [64];
    bit   rdy [64];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic exp_t base();
        exp_t e;
        e     = '0;
        e.rw  = 1'b1;
        e.pd  = m_pd;
        e.err = m_err;
        return e;
    endfunction

    task automatic check_rec(input string tag, input exp_t e);
        chk({tag, "_bus_valid"}, 32'(bus_valid),    32'(e.bv));
        chk({tag, "_rw"},        32'(rw),           32'(e.rw));
        chk({tag, "_sp_inc"},    32'(sp_increment), 32'(e.inc));
        chk({tag, "_sp_dec"},    32'(sp_decrement), 32'(e.dec));
        chk({tag, "_busy"},      32'(busy),         32'(e.busy));
        chk({tag, "_done"},      32'(done),         32'(e.done));
        chk({tag, "_stack_err"}, 32'(stack_error),  32'(e.err));
        chk({tag, "_address"},   32'(address_out),  32'(e.addr));
        chk({tag, "_db_out"},    32'(db_out),       32'(e.db));
        chk({tag, "_pull_data"}, 32'(pull_data),    32'(e.pd));
    endtask

    // ready pattern per cycle index: 0 = always 1, 1 = random, 2 = low for cycles 1..3
    task automatic fill_rdy(input int mode);
        for (int i = 0; i < 64; i++) begin
            case (mode)
                0:       rdy[i] = 1'b1;
                1:       rdy[i] = (i >= 30) ? 1'b1 : ($urandom_range(0, 99) < 65);
                default: rdy[i] = !(i >= 1 && i <= 3);
            endcase
        end
    endtask

    // Expected output for every cycle after the start edge, from the byte rules
    task automatic build(input bit p, input int n, input logic [23:0] data, output int len);
        int         k;
        logic [7:0] s;
        exp_t       e;
        bit         r;
        k = 1;
        s = m_sp;
        if (p) m_pd = '0;
        for (int b = 0; b < n; b++) begin
            if (!p) begin
                do begin
                    e = base(); e.bv = 1; e.rw = 0; e.busy = 1;
                    e.addr = {8'h01, s}; e.db = data[23 - 8*b -: 8];
                    tr[k] = e; r = rdy[k]; k++;
                end while (!r);
                m_mem[s] = data[23 - 8*b -: 8];
                e = base(); e.busy = 1; e.dec = 1; tr[k] = e; k++;
                if (WRAP && s == 8'h00) m_err = 1'b1;
                s = s - 8'd1;
            end else begin
                e = base(); e.busy = 1; e.inc = 1; tr[k] = e; k++;
                if (WRAP && s == 8'hFF) m_err = 1'b1;
                s = s + 8'd1;
                do begin
                    e = base(); e.bv = 1; e.busy = 1; e.addr = {8'h01, s};
                    tr[k] = e; r = rdy[k]; k++;
                end while (!r);
                m_pd[8*b +: 8] = m_mem[s];
            end
        end
        e = base(); e.busy = 1; e.done = 1; tr[k] = e; k++;
        tr[k] = base();
        len  = k;
        m_sp = s;
    endtask

    task automatic run_txn(input bit p, input int n, input logic [23:0] data,
                           input bit noise, output int done_cyc);
        int len;
        build(p, n, data, len);
        start = 1'b1; pull = p; byte_count = 2'(n); push_data = data; ready = rdy[0];
        @(posedge fclk); #1;
        done_cyc = 0;
        for (int k = 1; k <= len; k++) begin
            if (noise && k < len) begin
                start      = 1'($urandom_range(0, 1));
                pull       = 1'($urandom_range(0, 1));
                byte_count = 2'($urandom_range(0, 3));
                push_data  = 24'($urandom);
            end else begin
                start = 1'b0;
            end
            ready = rdy[k];
            @(negedge fclk);
            check_rec($sformatf("%s%0d_c%0d", p ? "pull" : "push", n, k), tr[k]);
            if (done && done_cyc == 0) done_cyc = k;
            @(posedge fclk); #1;
        end
        start = 1'b0;
        chk("sp_after_txn", 32'(sp_reg), 32'(m_sp));
    endtask

    task automatic set_sp(input logic [7:0] v);
        sp_ld_val = v; sp_ld = 1'b1;
        @(posedge fclk); #1;
        sp_ld = 1'b0;
        m_sp  = v;
    endtask

    task automatic load_mem();
        mem_copy = 1'b1;
        @(posedge fclk); #1;
        mem_copy = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        reset = 1'b1; start = 1'b0; pull = 1'b0; byte_count = '0;
        push_data = '0; ready = 1'b1; sp_ld = 1'b0; sp_ld_val = '0; mem_copy = 1'b0;
        m_pd = '0; m_err = 1'b0; m_sp = 8'hFF;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'($urandom);
        load_mem();
        set_sp(8'hFF);
        @(negedge fclk);
        check_rec("reset", base());
        @(posedge fclk); #1;
        reset = 1'b0;

        // Push 2 from FF
        fill_rdy(0);
        run_txn(1'b0, 2, 24'h1234AB, 1'b0, dc);
        chk("push2_done_cycle", 32'(dc), 32'd5);
        chk("push2_mem_01ff", 32'(mem[8'hFF]), 32'h12);
        chk("push2_mem_01fe", 32'(mem[8'hFE]), 32'h34);
        chk("push2_final_sp", 32'(sp_reg), 32'hFD);

        // Pull 3 from FC
        set_sp(8'hFC);
        m_mem[8'hFD] = 8'hAA; m_mem[8'hFE] = 8'hBB; m_mem[8'hFF] = 8'hCC;
        load_mem();
        run_txn(1'b1, 3, 24'h0, 1'b0, dc);
        chk("pull3_data", 32'(pull_data), 32'hCCBBAA);
        chk("pull3_done_cycle", 32'(dc), 32'd7);
        chk("pull3_final_sp", 32'(sp_reg), 32'hFF);

        // Push 1 with ready low for three cycles
        set_sp(8'h80);
        fill_rdy(2);
        run_txn(1'b0, 1, 24'h5A0000, 1'b0, dc);
        chk("push1_stall_done_cycle", 32'(dc), 32'd6);
        chk("push1_stall_mem", 32'(mem[8'h80]), 32'h5A);

        // byte_count=0 start is ignored
        start = 1'b1; pull = 1'b0; byte_count = 2'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge fclk);
            check_rec($sformatf("bc0_c%0d", i), base());
            @(posedge fclk); #1;
        end
        start = 1'b0;

        // Push 1 at SP 00 wraps
        set_sp(8'h00);
        fill_rdy(0);
        run_txn(1'b0, 1, 24'hE70000, 1'b0, dc);
        chk("wrap_mem_0100", 32'(mem[8'h00]), 32'hE7);
        chk("wrap_final_sp", 32'(sp_reg), 32'hFF);
        chk("wrap_stack_error", 32'(stack_error), 32'(WRAP));

        // Reset while stalled in a pull read
        set_sp(8'h10);
        start = 1'b1; pull = 1'b1; byte_count = 2'd2; ready = 1'b0;
        @(posedge fclk); #1;
        start = 1'b0;
        @(negedge fclk);
        chk("abort_inc_pulse", 32'(sp_increment), 32'd1);
        @(posedge fclk); #1;
        @(negedge fclk);
        chk("abort_rd_bus_valid", 32'(bus_valid), 32'd1);
        chk("abort_rd_address", 32'(address_out), 32'h0111);
        #2 reset = 1'b1;
        #1;
        m_sp = 8'h11; m_pd = '0; m_err = 1'b0;
        check_rec("abort_reset", base());
        @(posedge fclk); @(posedge fclk); #1;
        chk("abort_sp_held", 32'(sp_reg), 32'h11);
        reset = 1'b0;
        fill_rdy(0);
        run_txn(1'b1, 1, 24'h0, 1'b0, dc);
        chk("after_abort_done_cycle", 32'(dc), 32'd3);

        // Randomized sequences with stalls, busy-time start noise and idle gaps
        for (int t = 0; t < 40; t++) begin
            int gap;
            fill_rdy(1);
            run_txn(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)),
                    24'($urandom), 1'b1, dc);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                start = 1'($urandom_range(0, 1)); byte_count = 2'd0;
                @(negedge fclk);
                check_rec($sformatf("gap_t%0d", t), base());
                @(posedge fclk); #1;
            end
            start = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
